pipelined_controller: RTL and testbench
=======================================

Name: pipelined_controller

Overview:
- Parametrised successor to the single-register MIPS controller; sits between the ID stage and the datapath.
- Decodes the ID-stage instruction into a control bundle and carries it through the ID/EX, EX/MEM and MEM/WB registers.
- Tracks destination registers per stage, detects load-use hazards, applies branch/jump flushes and counts stall cycles.

Parameters:
- INSTR_W, 32: instruction width; opcode is [INSTR_W-1:INSTR_W-6].
- ALUOP_W, 6: width of the ALUOp field.
- REG_AW, 5: register-address width; rs=[25:21], rt=[20:16], rd=[15:11].
- LINK_REG, 31: destination register for jal.
- HAZARD_EN, 1: 0 ties Stall low and disables hazard detection.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  asynchronous, active-low reset
- Instruction  in  INSTR_W  ID-stage instruction
- InstrValid  in  1  Instruction is real; 0 inserts a bubble
- Flush  in  1  taken branch/jump; squash the ID instruction
- Stall  out  1  combinational; hold PC and IF/ID
- EX_ALUOp  out  ALUOP_W  ALU operation for the EX stage
- EX_ALUSrc  out  1  1 selects the immediate operand
- EX_Branch  out  1  EX-stage branch flag
- EX_Jump  out  1  EX-stage jump flag
- EX_WriteReg  out  REG_AW  EX-stage destination register
- EX_RegWrite  out  1  EX-stage register write enable
- MEM_MemRead  out  1  MEM-stage memory read
- MEM_MemWrite  out  1  MEM-stage memory write
- MEM_MemSize  out  2  00 word, 01 half, 10 byte
- MEM_WriteReg  out  REG_AW  MEM-stage destination register
- MEM_RegWrite  out  1  MEM-stage register write enable
- WB_MemtoReg  out  1  1 selects the ALU result, 0 selects memory data
- WB_Link  out  1  1 selects PC+8 as write data
- WB_WriteReg  out  REG_AW  WB-stage destination register
- WB_RegWrite  out  1  WB-stage register write enable
- IllegalOp  out  1  registered one-cycle pulse for an unknown opcode
- StallCount  out  CNT_W  saturating stall-cycle count

Behaviour:
- Reset: Rst low asynchronously clears every pipeline register, IllegalOp and StallCount to 0. All registered outputs read 0 while Rst is low and until the first edge after release. Stall is 0 while Rst is low.
- Decode (combinational, ID stage):
  - R-type 000000: RegDst, RegWrite, MemtoReg=1, ALUOp=000000.
  - addi/andi/ori/xori (001000/001100/001101/001110): ALUSrc, RegWrite, MemtoReg=1.
  - lw/lh/lb (100011/100001/100000): ALUSrc, MemRead, RegWrite, MemtoReg=0; MemSize 00/01/10.
  - sw/sh/sb (101011/101001/101000): ALUSrc, MemWrite; MemSize 00/01/10.
  - Branches regimm/beq/bne/bgtz/blez (000001/000100/000101/000111/000110): Branch only.
  - j 000010: Jump only.
  - jal 000011: Jump, Link, RegWrite, dest=LINK_REG.
  - Non-R-type: ALUOp = opcode.
  - Destination: Link ? LINK_REG : RegDst ? rd : rt.
  - RegWrite is forced 0 when the destination is register 0.
- Source use:
  - rs is used by every opcode except j and jal.
  - rt is used by R-type, beq, bne, sw, sh and sb.
- Load-use hazard: Stall=1 when all of the following hold:
  - HAZARD_EN=1, InstrValid=1 and Flush=0;
  - the ID/EX entry has MemRead=1 and a nonzero destination;
  - that destination equals a used source of the ID instruction.
- Pipeline advance, every rising edge:
  - EX/MEM takes ID/EX; MEM/WB takes EX/MEM.
  - ID/EX takes the decoded bundle, or all zeros when Flush, Stall, InstrValid=0 or an illegal opcode.
  - Priority: Flush > Stall > decode.
  - Stall lasts exactly one cycle per load-use pair. The load reaches MEM on the next edge, so the match clears.
- Latency: an instruction decoded at edge N drives EX_* after N, MEM_* after N+1 and WB_* after N+2.
- IllegalOp: registered 1 for one cycle after an edge where InstrValid=1, Flush=0, Stall=0 and the opcode is unsupported.
- StallCount: increments on each edge where Stall=1 and saturates at all-ones.
- Flush and Stall in the same cycle: Stall output is 0, a bubble is inserted and StallCount does not increment.
- Reset mid-operation: all in-flight bundles are discarded; nothing retires.

Test Plan:
- Reset: hold Rst=0 with Instruction=0x8D280000 -> all outputs 0 and Stall=0. Release, then apply the same word (lw $8,0($9)) -> after 1 edge EX_ALUOp=100011, EX_ALUSrc=1, EX_WriteReg=8, EX_RegWrite=1; after 2 edges MEM_MemRead=1, MEM_MemSize=00; after 3 edges WB_RegWrite=1, WB_MemtoReg=0, WB_WriteReg=8.
- Load-use: lw $8,0($9) then add $10,$8,$11 (0x010B5020) -> Stall=1 for exactly one cycle and ID/EX holds a bubble; the next cycle EX_WriteReg=10, EX_RegWrite=1, StallCount=1.
- Load to $0 and a non-dependent add: lw $0,0($9) then add $10,$8,$11 -> no stall.
- Flush: apply sw with Flush=1 -> after 2 edges MEM_MemWrite=0. Flush=1 together with a load-use pair -> Stall=0 and StallCount unchanged.
- jal 0x0C000010 -> after 3 edges WB_WriteReg=31, WB_Link=1, WB_RegWrite=1. addi $0,$0,5 -> EX_RegWrite=0.
- Illegal opcode 111111 -> IllegalOp=1 for one cycle and bubbles downstream. With CNT_W=2, run 5 load-use stalls -> StallCount holds at 3.

Source files
------------

// File: rtl/pipelined_controller.sv
// Purpose : MIPS ID-stage decoder that carries the control bundle through ID/EX, EX/MEM and MEM/WB,
//           detects load-use hazards, squashes flushed instructions and counts stall cycles.
// Latency : decoded at edge N -> EX_* after N, MEM_* after N+1, WB_* after N+2; Stall is combinational.
// Backpressure: Stall holds PC and IF/ID for one cycle per load-use pair; a bubble is inserted into ID/EX.
// Ports   : Clk/Rst (async active-low); Instruction/InstrValid/Flush from ID; Stall to the fetch logic;
//           EX_*/MEM_*/WB_* per-stage controls; IllegalOp pulse; StallCount saturating counter.
module pipelined_controller #(
   parameter int INSTR_W   = 32,
   parameter int ALUOP_W   = 6,
   parameter int REG_AW    = 5,
   parameter int LINK_REG  = 31,
   parameter int HAZARD_EN = 1,
   parameter int CNT_W     = 16
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic [INSTR_W-1:0] Instruction,
   input  logic               InstrValid,
   input  logic               Flush,
   output logic               Stall,
   output logic [ALUOP_W-1:0] EX_ALUOp,
   output logic               EX_ALUSrc,
   output logic               EX_Branch,
   output logic               EX_Jump,
   output logic [REG_AW-1:0]  EX_WriteReg,
   output logic               EX_RegWrite,
   output logic               MEM_MemRead,
   output logic               MEM_MemWrite,
   output logic [1:0]         MEM_MemSize,
   output logic [REG_AW-1:0]  MEM_WriteReg,
   output logic               MEM_RegWrite,
   output logic               WB_MemtoReg,
   output logic               WB_Link,
   output logic [REG_AW-1:0]  WB_WriteReg,
   output logic               WB_RegWrite,
   output logic               IllegalOp,
   output logic [CNT_W-1:0]   StallCount
);

   typedef struct packed {
      logic [ALUOP_W-1:0] alu_op;
      logic               alu_src;
      logic               branch;
      logic               jump;
      logic               mem_read;
      logic               mem_write;
      logic [1:0]         mem_size;
      logic               memto_reg;
      logic               link;
      logic [REG_AW-1:0]  wr_reg;
      logic               reg_write;
   } ctrl_t;

   localparam logic [5:0] OP_RTYPE  = 6'b000000;
   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_JAL    = 6'b000011;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;
   localparam logic [5:0] OP_ADDI   = 6'b001000;
   localparam logic [5:0] OP_ANDI   = 6'b001100;
   localparam logic [5:0] OP_ORI    = 6'b001101;
   localparam logic [5:0] OP_XORI   = 6'b001110;
   localparam logic [5:0] OP_LB     = 6'b100000;
   localparam logic [5:0] OP_LH     = 6'b100001;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SB     = 6'b101000;
   localparam logic [5:0] OP_SH     = 6'b101001;
   localparam logic [5:0] OP_SW     = 6'b101011;

   logic [5:0]        opcode;
   logic [REG_AW-1:0] rs, rt, rd;
   ctrl_t             dec;
   logic              legal, rs_used, rt_used, reg_dst, hazard;
   ctrl_t             idex_q, idex_d, exmem_q, memwb_q;
   logic              illegal_q, illegal_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              unused_bits;

   assign opcode = Instruction[INSTR_W-1 -: 6];
   assign rs     = Instruction[21 +: REG_AW];
   assign rt     = Instruction[16 +: REG_AW];
   assign rd     = Instruction[11 +: REG_AW];

   // ID-stage decode
   always_comb begin
      dec         = '0;
      dec.alu_op  = ALUOP_W'(opcode);
      legal       = 1'b1;
      rs_used     = 1'b1;
      rt_used     = 1'b0;
      reg_dst     = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            reg_dst = 1'b1; dec.reg_write = 1'b1; dec.memto_reg = 1'b1;
            dec.alu_op = '0; rt_used = 1'b1;
         end
         OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
            dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.memto_reg = 1'b1;
         end
         OP_LW, OP_LH, OP_LB: begin
            dec.alu_src = 1'b1; dec.mem_read = 1'b1; dec.reg_write = 1'b1;
            dec.mem_size = (opcode == OP_LW) ? 2'b00 : (opcode == OP_LH) ? 2'b01 : 2'b10;
         end
         OP_SW, OP_SH, OP_SB: begin
            dec.alu_src = 1'b1; dec.mem_write = 1'b1; rt_used = 1'b1;
            dec.mem_size = (opcode == OP_SW) ? 2'b00 : (opcode == OP_SH) ? 2'b01 : 2'b10;
         end
         OP_REGIMM, OP_BGTZ, OP_BLEZ: dec.branch = 1'b1;
         OP_BEQ, OP_BNE: begin
            dec.branch = 1'b1; rt_used = 1'b1;
         end
         OP_J: begin
            dec.jump = 1'b1; rs_used = 1'b0;
         end
         OP_JAL: begin
            dec.jump = 1'b1; dec.link = 1'b1; dec.reg_write = 1'b1; rs_used = 1'b0;
         end
         default: legal = 1'b0;
      endcase
      dec.wr_reg = dec.link ? REG_AW'(LINK_REG) : (reg_dst ? rd : rt);
      // writes to $0 are architecturally dead, so drop the enable early
      if (dec.wr_reg == '0) dec.reg_write = 1'b0;
   end

   // Load-use: the load in ID/EX only produces data in MEM, one cycle too late for EX.
   always_comb begin
      hazard = 1'b0;
      if (HAZARD_EN != 0 && InstrValid && !Flush && idex_q.mem_read && idex_q.wr_reg != '0)
         hazard = (rs_used && rs == idex_q.wr_reg) || (rt_used && rt == idex_q.wr_reg);
   end
   assign Stall = hazard;

   // Flush dominates Stall because hazard is already gated by !Flush.
   always_comb begin
      idex_d = dec;
      if (Flush || hazard || !InstrValid || !legal) idex_d = '0;
      illegal_d = InstrValid && !Flush && !hazard && !legal;
      cnt_d = cnt_q;
      if (hazard && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         idex_q    <= '0;
         exmem_q   <= '0;
         memwb_q   <= '0;
         illegal_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         idex_q    <= idex_d;
         exmem_q   <= idex_q;
         memwb_q   <= exmem_q;
         illegal_q <= illegal_d;
         cnt_q     <= cnt_d;
      end
   end

   assign EX_ALUOp     = idex_q.alu_op;
   assign EX_ALUSrc    = idex_q.alu_src;
   assign EX_Branch    = idex_q.branch;
   assign EX_Jump      = idex_q.jump;
   assign EX_WriteReg  = idex_q.wr_reg;
   assign EX_RegWrite  = idex_q.reg_write;
   assign MEM_MemRead  = exmem_q.mem_read;
   assign MEM_MemWrite = exmem_q.mem_write;
   assign MEM_MemSize  = exmem_q.mem_size;
   assign MEM_WriteReg = exmem_q.wr_reg;
   assign MEM_RegWrite = exmem_q.reg_write;
   assign WB_MemtoReg  = memwb_q.memto_reg;
   assign WB_Link      = memwb_q.link;
   assign WB_WriteReg  = memwb_q.wr_reg;
   assign WB_RegWrite  = memwb_q.reg_write;
   assign IllegalOp    = illegal_q;
   assign StallCount   = cnt_q;

   // fields that later stages never look at, plus instruction bits outside the decoded fields
   assign unused_bits = ^{Instruction, exmem_q, memwb_q};

endmodule

// File: tb/tb_pipelined_controller.sv
// Purpose : scoreboard bench for pipelined_controller (default instance plus a CNT_W=2 instance).
// Latency : expected bundle pushed when an instruction is driven, compared at EX/MEM/WB on later edges.
// Backpressure: the bench re-presents the same instruction while its model predicts Stall.
module tb_pipelined_controller;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [31:0] Instruction;
   logic        InstrValid, Flush;

   logic        Stall, EX_ALUSrc, EX_Branch, EX_Jump, EX_RegWrite;
   logic [5:0]  EX_ALUOp;
   logic [4:0]  EX_WriteReg, MEM_WriteReg, WB_WriteReg;
   logic        MEM_MemRead, MEM_MemWrite, MEM_RegWrite;
   logic [1:0]  MEM_MemSize;
   logic        WB_MemtoReg, WB_Link, WB_RegWrite, IllegalOp;
   logic [15:0] StallCount;

   logic        s2_Stall, s2_EX_ALUSrc, s2_EX_Branch, s2_EX_Jump, s2_EX_RegWrite;
   logic [5:0]  s2_EX_ALUOp;
   logic [4:0]  s2_EX_WriteReg, s2_MEM_WriteReg, s2_WB_WriteReg;
   logic        s2_MEM_MemRead, s2_MEM_MemWrite, s2_MEM_RegWrite;
   logic [1:0]  s2_MEM_MemSize;
   logic        s2_WB_MemtoReg, s2_WB_Link, s2_WB_RegWrite, s2_IllegalOp;
   logic [1:0]  s2_StallCount;

   pipelined_controller dut (
      .Clk(Clk), .Rst(Rst), .Instruction(Instruction), .InstrValid(InstrValid), .Flush(Flush),
      .Stall(Stall), .EX_ALUOp(EX_ALUOp), .EX_ALUSrc(EX_ALUSrc), .EX_Branch(EX_Branch),
      .EX_Jump(EX_Jump), .EX_WriteReg(EX_WriteReg), .EX_RegWrite(EX_RegWrite),
      .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .MEM_MemSize(MEM_MemSize),
      .MEM_WriteReg(MEM_WriteReg), .MEM_RegWrite(MEM_RegWrite), .WB_MemtoReg(WB_MemtoReg),
      .WB_Link(WB_Link), .WB_WriteReg(WB_WriteReg), .WB_RegWrite(WB_RegWrite),
      .IllegalOp(IllegalOp), .StallCount(StallCount)
   );

   pipelined_controller #(.CNT_W(2)) dut_sat (
      .Clk(Clk), .Rst(Rst), .Instruction(Instruction), .InstrValid(InstrValid), .Flush(Flush),
      .Stall(s2_Stall), .EX_ALUOp(s2_EX_ALUOp), .EX_ALUSrc(s2_EX_ALUSrc), .EX_Branch(s2_EX_Branch),
      .EX_Jump(s2_EX_Jump), .EX_WriteReg(s2_EX_WriteReg), .EX_RegWrite(s2_EX_RegWrite),
      .MEM_MemRead(s2_MEM_MemRead), .MEM_MemWrite(s2_MEM_MemWrite), .MEM_MemSize(s2_MEM_MemSize),
      .MEM_WriteReg(s2_MEM_WriteReg), .MEM_RegWrite(s2_MEM_RegWrite), .WB_MemtoReg(s2_WB_MemtoReg),
      .WB_Link(s2_WB_Link), .WB_WriteReg(s2_WB_WriteReg), .WB_RegWrite(s2_WB_RegWrite),
      .IllegalOp(s2_IllegalOp), .StallCount(s2_StallCount)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [5:0] alu_op;
      logic       alu_src, branch, jump, mem_read, mem_write;
      logic [1:0] mem_size;
      logic       memto_reg, link;
      logic [4:0] wr_reg;
      logic       reg_write;
   } exp_t;

   typedef struct {
      logic [31:0] ins;
      logic        vld;
      logic        fl;
   } op_t;

   exp_t        exp_q[$];
   op_t         prog[$];
   int          n_chk  = 0;
   int          n_fail = 0;
   logic [15:0] cnt16;
   logic [1:0]  cnt2;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference decode written from the opcode table.
   function automatic exp_t ref_dec(input logic [31:0] ins, output logic legal,
                                    output logic rs_u, output logic rt_u);
      exp_t       e;
      logic [5:0] op;
      logic       use_rd;
      e = '0; op = ins[31:26]; use_rd = 1'b0;
      legal = 1'b1; rs_u = 1'b1; rt_u = 1'b0;
      e.alu_op = op;
      case (op)
         6'h00: begin use_rd = 1'b1; e.reg_write = 1'b1; e.memto_reg = 1'b1; e.alu_op = 6'h00; rt_u = 1'b1; end
         6'h08, 6'h0C, 6'h0D, 6'h0E: begin e.alu_src = 1'b1; e.reg_write = 1'b1; e.memto_reg = 1'b1; end
         6'h23: begin e.alu_src = 1'b1; e.mem_read = 1'b1; e.reg_write = 1'b1; e.mem_size = 2'b00; end
         6'h21: begin e.alu_src = 1'b1; e.mem_read = 1'b1; e.reg_write = 1'b1; e.mem_size = 2'b01; end
         6'h20: begin e.alu_src = 1'b1; e.mem_read = 1'b1; e.reg_write = 1'b1; e.mem_size = 2'b10; end
         6'h2B: begin e.alu_src = 1'b1; e.mem_write = 1'b1; e.mem_size = 2'b00; rt_u = 1'b1; end
         6'h29: begin e.alu_src = 1'b1; e.mem_write = 1'b1; e.mem_size = 2'b01; rt_u = 1'b1; end
         6'h28: begin e.alu_src = 1'b1; e.mem_write = 1'b1; e.mem_size = 2'b10; rt_u = 1'b1; end
         6'h01, 6'h06, 6'h07: e.branch = 1'b1;
         6'h04, 6'h05: begin e.branch = 1'b1; rt_u = 1'b1; end
         6'h02: begin e.jump = 1'b1; rs_u = 1'b0; end
         6'h03: begin e.jump = 1'b1; e.link = 1'b1; e.reg_write = 1'b1; rs_u = 1'b0; end
         default: legal = 1'b0;
      endcase
      e.wr_reg = e.link ? 5'd31 : (use_rd ? ins[15:11] : ins[20:16]);
      if (e.wr_reg == 5'd0) e.reg_write = 1'b0;
      return e;
   endfunction

   task automatic check_all_zero(input string tag);
      chk({tag, "_Stall"}, Stall, 0);
      chk({tag, "_EX"}, {EX_ALUOp, EX_ALUSrc, EX_Branch, EX_Jump, EX_WriteReg, EX_RegWrite}, 0);
      chk({tag, "_MEM"}, {MEM_MemRead, MEM_MemWrite, MEM_MemSize, MEM_WriteReg, MEM_RegWrite}, 0);
      chk({tag, "_WB"}, {WB_MemtoReg, WB_Link, WB_WriteReg, WB_RegWrite}, 0);
      chk({tag, "_Illegal"}, IllegalOp, 0);
      chk({tag, "_Count"}, StallCount, 0);
      chk({tag, "_CountSat"}, s2_StallCount, 0);
   endtask

   task automatic init_model();
      exp_q.delete();
      repeat (3) exp_q.push_back('0);
      cnt16 = '0;
      cnt2  = '0;
   endtask

   // Drive one ID-stage cycle, predict, clock, compare all three stages.
   task automatic step(input logic [31:0] ins, input logic vld, input logic fl, output logic stalled);
      exp_t d, prev, nxt;
      logic legal, rs_u, rt_u, st, ill;
      Instruction = ins; InstrValid = vld; Flush = fl;
      #1;
      d    = ref_dec(ins, legal, rs_u, rt_u);
      prev = exp_q[$];
      st   = vld && !fl && prev.mem_read && prev.wr_reg != 5'd0 &&
             ((rs_u && ins[25:21] == prev.wr_reg) || (rt_u && ins[20:16] == prev.wr_reg));
      chk("Stall", Stall, st);
      chk("Stall_sat", s2_Stall, st);
      nxt = (fl || st || !vld || !legal) ? exp_t'('0) : d;
      exp_q.push_back(nxt);
      ill = vld && !fl && !st && !legal;
      if (st) begin
         if (cnt16 != 16'hFFFF) cnt16 = cnt16 + 16'd1;
         if (cnt2 != 2'd3) cnt2 = cnt2 + 2'd1;
      end
      @(posedge Clk);
      #1;
      void'(exp_q.pop_front());
      chk("EX_ALUOp", EX_ALUOp, exp_q[2].alu_op);
      chk("EX_ALUSrc", EX_ALUSrc, exp_q[2].alu_src);
      chk("EX_Branch", EX_Branch, exp_q[2].branch);
      chk("EX_Jump", EX_Jump, exp_q[2].jump);
      chk("EX_WriteReg", EX_WriteReg, exp_q[2].wr_reg);
      chk("EX_RegWrite", EX_RegWrite, exp_q[2].reg_write);
      chk("MEM_MemRead", MEM_MemRead, exp_q[1].mem_read);
      chk("MEM_MemWrite", MEM_MemWrite, exp_q[1].mem_write);
      chk("MEM_MemSize", MEM_MemSize, exp_q[1].mem_size);
      chk("MEM_WriteReg", MEM_WriteReg, exp_q[1].wr_reg);
      chk("MEM_RegWrite", MEM_RegWrite, exp_q[1].reg_write);
      chk("WB_MemtoReg", WB_MemtoReg, exp_q[0].memto_reg);
      chk("WB_Link", WB_Link, exp_q[0].link);
      chk("WB_WriteReg", WB_WriteReg, exp_q[0].wr_reg);
      chk("WB_RegWrite", WB_RegWrite, exp_q[0].reg_write);
      chk("IllegalOp", IllegalOp, ill);
      chk("StallCount", StallCount, cnt16);
      chk("StallCount_sat", s2_StallCount, cnt2);
      stalled = st;
   endtask

   // Replays an instruction while stalled, as a held IF/ID register would.
   task automatic run_prog();
      int   idx   = 0;
      int   guard = 0;
      logic st;
      while (idx < prog.size() && guard < 500) begin
         step(prog[idx].ins, prog[idx].vld, prog[idx].fl, st);
         if (!st) idx++;
         guard++;
      end
      if (idx < prog.size()) begin
         n_chk++; n_fail++;
         $display("FAIL run_prog: cycle budget expired at index %0d", idx);
      end
      prog.delete();
   endtask

   task automatic add_op(input logic [31:0] ins, input logic vld, input logic fl);
      op_t o;
      o.ins = ins; o.vld = vld; o.fl = fl;
      prog.push_back(o);
   endtask

   localparam logic [31:0] LW8   = 32'h8D28_0000; // lw  $8,0($9)
   localparam logic [31:0] ADD10 = 32'h010B_5020; // add $10,$8,$11

   initial begin
      Rst = 1'b0; Instruction = LW8; InstrValid = 1'b1; Flush = 1'b0;
      #2;
      check_all_zero("rst");
      @(posedge Clk); #1;
      check_all_zero("rst_edge");
      InstrValid = 1'b0;
      @(negedge Clk);
      Rst = 1'b1;
      init_model();

      // first load-use pair
      add_op(LW8, 1, 0);
      add_op(ADD10, 1, 0);
      run_prog();
      chk("after_loaduse_EX_WriteReg", EX_WriteReg, 10);
      chk("after_loaduse_EX_RegWrite", EX_RegWrite, 1);
      chk("after_loaduse_StallCount", StallCount, 1);

      add_op(32'h8D20_0000, 1, 0);  // lw $0,0($9)
      add_op(ADD10, 1, 0);          // no stall: load targets $0
      add_op(32'hAD28_0000, 1, 1);  // sw flushed
      add_op(LW8, 1, 0);
      add_op(ADD10, 1, 1);          // load-use pair with Flush
      add_op(32'h0C00_0010, 1, 0);  // jal
      add_op(32'h2000_0005, 1, 0);  // addi $0,$0,5
      add_op(32'hFC00_0000, 1, 0);  // illegal opcode
      add_op(LW8, 0, 0);            // invalid slot
      add_op(32'hA52B_0002, 1, 0);  // sh $11,2($9)
      add_op(32'h810C_0001, 1, 0);  // lb $12,1($8)
      add_op(32'h1183_0000, 1, 0);  // beq $12,$3 (rs hazard)
      add_op(32'h852D_0000, 1, 0);  // lh $13,0($9)
      add_op(32'hA12D_0000, 1, 0);  // sb $13 (rt hazard)
      add_op(LW8, 1, 0);
      add_op(32'h0800_0004, 1, 0);  // j: no sources
      add_op(32'h3508_0001, 1, 0);  // ori $8,$8,1
      add_op(32'h3128_00FF, 1, 0);  // andi $8,$9,0xff
      add_op(32'h1509_0000, 1, 0);  // bne $8,$9
      for (int i = 0; i < 4; i++) begin
         add_op(LW8, 1, 0);
         add_op(ADD10, 1, 0);
      end
      repeat (3) add_op(32'h0000_0000, 1, 0);
      run_prog();
      chk("final_StallCount", StallCount, 7);
      chk("final_StallCount_sat", s2_StallCount, 3);

      // reset while a load is in flight
      add_op(LW8, 1, 0);
      add_op(32'h0C00_0010, 1, 0);
      run_prog();
      @(negedge Clk);
      Rst = 1'b0;
      #1;
      check_all_zero("midrst");
      InstrValid = 1'b0;
      @(negedge Clk);
      Rst = 1'b1;
      init_model();
      repeat (3) add_op(32'h0000_0000, 1, 0);
      run_prog();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
